// File: rtl/alu_req_pkg.sv
// Shared types for the ALU request master: FSM encoding, result status codes
// and the packed operation record carried through the queue.
package alu_req_pkg;

  localparam int OPA_W = 2;
  localparam int OPB_W = 2;
  localparam int SEL_W = 4;
  localparam int RES_W = 7;
  localparam int OP_W  = SEL_W + OPB_W + OPA_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_EXEC    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [1:0] ST_OK         = 2'b00;
  localparam logic [1:0] ST_TIMEOUT    = 2'b01;
  localparam logic [1:0] ST_GRANT_LOST = 2'b10;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [OPB_W-1:0] b;
    logic [OPA_W-1:0] a;
  } op_t;

endpackage

// File: rtl/alu_req_master_if.sv
// Producer, arbiter and ALU-side signals of the request master, bundled so the
// master and its environment see opposite directions.
interface alu_req_master_if;
  import alu_req_pkg::*;

  logic             op_valid;
  logic             op_ready;
  logic [OPA_W-1:0] op_a;
  logic [OPB_W-1:0] op_b;
  logic [SEL_W-1:0] op_sel;
  logic             req;
  logic             gnt;
  logic [OPA_W-1:0] alu_a;
  logic [OPB_W-1:0] alu_b;
  logic [SEL_W-1:0] alu_sel;
  logic [RES_W-1:0] alu_out;
  logic             alu_carry;
  logic             res_valid;
  logic [RES_W-1:0] res_data;
  logic             res_carry;
  logic [1:0]       res_status;
  logic             busy;

  modport master (
    input  op_valid, op_a, op_b, op_sel, gnt, alu_out, alu_carry,
    output op_ready, req, alu_a, alu_b, alu_sel,
           res_valid, res_data, res_carry, res_status, busy
  );

  modport slave (
    output op_valid, op_a, op_b, op_sel, gnt, alu_out, alu_carry,
    input  op_ready, req, alu_a, alu_b, alu_sel,
           res_valid, res_data, res_carry, res_status, busy
  );

endinterface

// File: rtl/alu_req_fifo.sv
// Registered operation queue; the head entry is visible on rdata while not empty.
module alu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_req_master.sv
// Initiator side of the shared-ALU req/gnt handshake: queues operations,
// wins the ALU for each, captures the result and hands the grant back.
module alu_req_master
  import alu_req_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 15,
  parameter int HOLD_CYCLES = 1
) (
  input logic              clock,
  input logic              reset,
  alu_req_master_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT + HOLD_CYCLES + 1);

  state_t           state, state_nx;
  op_t              op_q, op_nx, fifo_head, fifo_in;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             rv_q, rv_nx;
  logic [RES_W-1:0] rd_q, rd_nx;
  logic             rc_q, rc_nx;
  logic [1:0]       rs_q, rs_nx;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic             drive_bus;

  assign fifo_in = {bus.op_sel, bus.op_b, bus.op_a};

  alu_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(OP_W)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (bus.op_valid),
    .pop   (fifo_pop),
    .wdata (fifo_in),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      op_q  <= '0;
      cnt   <= '0;
      rv_q  <= 1'b0;
      rd_q  <= '0;
      rc_q  <= 1'b0;
      rs_q  <= ST_OK;
    end else begin
      state <= state_nx;
      op_q  <= op_nx;
      cnt   <= cnt_nx;
      rv_q  <= rv_nx;
      rd_q  <= rd_nx;
      rc_q  <= rc_nx;
      rs_q  <= rs_nx;
    end
  end

  // One counter serves both the REQ wait and the EXEC hold, cleared on entry.
  always_comb begin
    state_nx = state;
    op_nx    = op_q;
    cnt_nx   = cnt;
    rv_nx    = 1'b0;
    rd_nx    = rd_q;
    rc_nx    = rc_q;
    rs_nx    = rs_q;
    fifo_pop = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_nx    = fifo_head;
          cnt_nx   = '0;
          state_nx = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.gnt) begin
          cnt_nx   = '0;
          state_nx = S_EXEC;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          rv_nx    = 1'b1;
          rd_nx    = '0;
          rc_nx    = 1'b0;
          rs_nx    = ST_TIMEOUT;
          cnt_nx   = '0;
          state_nx = S_RELEASE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_EXEC: begin
        if (!bus.gnt) begin
          rv_nx    = 1'b1;
          rd_nx    = '0;
          rc_nx    = 1'b0;
          rs_nx    = ST_GRANT_LOST;
          state_nx = S_RELEASE;
        end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          rv_nx    = 1'b1;
          rd_nx    = bus.alu_out;
          rc_nx    = bus.alu_carry;
          rs_nx    = ST_OK;
          state_nx = S_RELEASE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        // Wait for the arbiter to drop gnt so the next req starts from its idle.
        if (!bus.gnt) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign drive_bus      = (state == S_REQ) || (state == S_EXEC);
  assign bus.req        = drive_bus;
  assign bus.alu_a      = drive_bus ? op_q.a   : '0;
  assign bus.alu_b      = drive_bus ? op_q.b   : '0;
  assign bus.alu_sel    = drive_bus ? op_q.sel : '0;
  assign bus.op_ready   = !fifo_full;
  assign bus.busy       = (state != S_IDLE) || !fifo_empty;
  assign bus.res_valid  = rv_q;
  assign bus.res_data   = rd_q;
  assign bus.res_carry  = rc_q;
  assign bus.res_status = rs_q;

endmodule

// File: tb/tb_alu_req_master.sv
// Self-checking bench for alu_req_master: arbiter and ALU models drive the
// bus, a result scoreboard is filled at push time and drained on res_valid.
module tb_alu_req_master;
  import alu_req_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 15;
  localparam int HOLD  = 2;

  logic clock;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   n_pulses;
  int   gnt_mode;
  int   push_cyc;
  logic [9:0] sb[$];

  alu_req_master_if bus ();

  alu_req_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .HOLD_CYCLES(HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // ALU model: returns {carry, result}
  function automatic logic [7:0] alu_fn(input logic [1:0] a, input logic [1:0] b,
                                        input logic [3:0] sel);
    logic [2:0] t;
    logic [7:0] r;
    t = '0;
    case (sel)
      4'b0000: begin t = {1'b0, a} + {1'b0, b}; r = {t[2], 4'b0, t}; end
      4'b0001: begin t = {1'b0, a} - {1'b0, b}; r = {t[2], 5'b0, t[1:0]}; end
      4'b0010: r = {4'b0, ({2'b0, a} * {2'b0, b})};
      4'b1110: r = {7'b0, (a > b)};
      4'b1111: r = {7'b0, (a == b)};
      default: r = {^{a, b}, 1'b0, sel, a ^ b};
    endcase
    return r;
  endfunction

  assign {bus.alu_carry, bus.alu_out} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);

  // Arbiter model: 0 never grants, 1 grants a cycle after req, 2 one-cycle grant pulses
  always @(posedge clock or posedge reset) begin
    if (reset) bus.gnt <= 1'b0;
    else case (gnt_mode)
      1:       bus.gnt <= bus.req;
      2:       bus.gnt <= bus.req & ~bus.gnt;
      default: bus.gnt <= 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && bus.res_valid) begin
      logic [9:0] e;
      n_pulses++;
      chk("req_low_at_pulse", bus.req, 0);
      chk("bus_idle_at_pulse", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);
      chk("pulse_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("res_status", bus.res_status, e[9:8]);
        chk("res_carry", bus.res_carry, e[7]);
        chk("res_data", bus.res_data, e[6:0]);
      end
    end
  end

  task automatic push_op(input logic [1:0] a, input logic [1:0] b, input logic [3:0] sel,
                         input logic [1:0] st, input bit expect_res);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.op_ready) begin ok = 1; break; end
    end
    chk("push_ready", ok, 1);
    bus.op_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_sel   = sel;
    if (expect_res) sb.push_back((st == ST_OK) ? {ST_OK, alu_fn(a, b, sel)} : {st, 8'h00});
    @(posedge clock);
    #1;
    push_cyc     = cyc;
    bus.op_valid = 1'b0;
  endtask

  task automatic wait_pulse();
    bit seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (bus.res_valid) begin seen = 1; break; end
    end
    chk("pulse_seen", seen, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!bus.busy && !bus.gnt) begin done = 1; break; end
    end
    chk("idle_reached", done, 1);
    chk("idle_req", bus.req, 0);
  endtask

  task automatic single_add(input string tag);
    push_op(2'd2, 2'd1, 4'b0000, ST_OK, 1);
    chk({tag, "_req_before"}, bus.req, 0);
    @(posedge clock);
    #1;
    chk({tag, "_req_after_1"}, bus.req, 1);
    wait_pulse();
    chk({tag, "_latency"}, cyc - push_cyc, 3 + HOLD);
    chk({tag, "_data"}, bus.res_data, 3);
    wait_idle();
  endtask

  initial begin
    int req_cnt, low_cnt, p0;
    bit drained;
    cyc = 0; n_checks = 0; n_fail = 0; n_pulses = 0; gnt_mode = 1; push_cyc = 0;
    reset = 1'b0;
    bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.op_sel = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_req", bus.req, 0);
    chk("rst_bus", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);
    chk("rst_res", {bus.res_valid, bus.res_data, bus.res_carry, bus.res_status}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.op_ready, 1);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    single_add("add");

    // Back-to-back compares; req must drop for at least two cycles between them
    push_op(2'd3, 2'd1, 4'b1110, ST_OK, 1);
    push_op(2'd2, 2'd2, 4'b1111, ST_OK, 1);
    wait_pulse();
    low_cnt = 0;
    for (int i = 0; i < 20 && !bus.req; i++) begin
      low_cnt++;
      @(negedge clock);
    end
    chk("cmp_req_gap_ge2", (low_cnt >= 2), 1);
    wait_pulse();
    wait_idle();

    // Timeout with no grant
    gnt_mode = 0;
    p0 = n_pulses;
    push_op(2'd1, 2'd1, 4'b0000, ST_TIMEOUT, 1);
    req_cnt = 0;
    for (int i = 0; i < 60 && n_pulses == p0; i++) begin
      @(negedge clock);
      if (bus.req) req_cnt++;
    end
    chk("tmo_req_cycles", req_cnt, TMO);
    wait_idle();

    // Fill the queue while the arbiter is withholding grant
    for (int i = 0; i < 6; i++) begin
      logic [1:0] a, b;
      logic [3:0] s;
      a = 2'(i + 1);
      b = 2'(i);
      s = (i % 2 == 0) ? 4'b0001 : 4'b0010;
      @(negedge clock);
      chk("fifo_ready", bus.op_ready, (i < 5));
      bus.op_valid = 1'b1;
      bus.op_a = a; bus.op_b = b; bus.op_sel = s;
      if (i < 5) sb.push_back({ST_OK, alu_fn(a, b, s)});
      @(posedge clock);
      #1 bus.op_valid = 1'b0;
    end
    gnt_mode = 1;
    drained = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (sb.size() == 0) begin drained = 1; break; end
    end
    chk("fifo_drained", drained, 1);
    wait_idle();

    // Grant withdrawn in the first EXEC cycle
    gnt_mode = 2;
    push_op(2'd3, 2'd2, 4'b0001, ST_GRANT_LOST, 1);
    wait_pulse();
    @(negedge clock);
    chk("lost_req_next", bus.req, 0);
    wait_idle();
    gnt_mode = 1;

    // Asynchronous reset while in EXEC: no pulse for the aborted op
    push_op(2'd2, 2'd1, 4'b0000, ST_OK, 0);
    repeat (3) @(posedge clock);
    #2;
    chk("arst_pre_req", bus.req, 1);
    chk("arst_pre_a", bus.alu_a, 2);
    reset = 1'b1;
    #1;
    chk("arst_req", bus.req, 0);
    chk("arst_bus", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_ready", bus.op_ready, 1);
    chk("arst_valid", bus.res_valid, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    single_add("add2");

    chk("sb_empty", sb.size(), 0);
    chk("pulse_count", n_pulses, 11);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_req_master.md
Name: alu_req_master

Overview:
- Initiator side of the two-client req/gnt arbitration handshake that guards the shared ALU.
- Buffers queued ALU operations (2-bit A, 2-bit B, 4-bit select) in a small FIFO.
- For each operation: raises req, waits for gnt, drives the ALU operands, captures the 7-bit result and carry, then releases req and waits for gnt to drop.
- Sits between an operation producer and one request/grant pair of the arbiter plus the ALU operand bus.

Parameters:
- FIFO_DEPTH, 4, operation queue depth (power of two, >=2).
- TIMEOUT, 15, maximum cycles spent in REQ without gnt before the operation is abandoned.
- HOLD_CYCLES, 1, cycles the operands are held in EXEC before the result is captured (>=1).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  producer offers an operation.
- op_ready  out  1  FIFO not full; a push occurs when op_valid & op_ready.
- op_a  in  2  operand A.
- op_b  in  2  operand B.
- op_sel  in  4  ALU select code.
- req  out  1  request to the arbiter.
- gnt  in  1  grant from the arbiter.
- alu_a  out  2  operand A to the ALU.
- alu_b  out  2  operand B to the ALU.
- alu_sel  out  4  select code to the ALU.
- alu_out  in  7  ALU result.
- alu_carry  in  1  ALU carry.
- res_valid  out  1  one-cycle result pulse.
- res_data  out  7  captured result.
- res_carry  out  1  captured carry.
- res_status  out  2  00 OK, 01 TIMEOUT, 10 GRANT_LOST.
- busy  out  1  FSM is not in IDLE, or the FIFO is not empty.

Behaviour:
- Reset (async, active-high) forces the following immediately, including mid-operation; no result pulse is generated for an aborted operation:
  - state IDLE, FIFO emptied, timeout counter 0;
  - req=0, alu_a/alu_b/alu_sel=0;
  - res_valid=0, res_data=0, res_carry=0, res_status=00;
  - busy=0, op_ready=1.
- FIFO:
  - Registered, FIFO_DEPTH entries.
  - op_ready = !full; a push when full is impossible.
  - Push and pop in the same cycle is legal and leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, REQ, EXEC, RELEASE.
  - IDLE: if the FIFO is not empty, pop the head into the op register and go to REQ. An op pushed at edge N is popped at edge N+1.
  - REQ: req=1 and the timeout counter increments each cycle.
    - gnt=1 sampled -> EXEC, counter cleared.
    - Counter reaches TIMEOUT with gnt=0 -> pulse res_valid with res_status=01, res_data=0, res_carry=0, then go to RELEASE.
  - EXEC: req=1 for HOLD_CYCLES cycles.
    - On the last EXEC edge, register alu_out/alu_carry into res_data/res_carry, pulse res_valid with res_status=00, then go to RELEASE.
    - gnt=0 sampled during EXEC -> pulse res_valid with res_status=10, res_data=0, then go to RELEASE.
  - RELEASE: req=0. Stay until gnt=0 is sampled, then go to IDLE. This guarantees the arbiter has returned to its idle state before the next request.
- Operand bus: alu_a/alu_b/alu_sel are driven from the op register in REQ and EXEC, and are 0 in IDLE and RELEASE.
- Result outputs:
  - res_valid is a registered single-cycle pulse with no backpressure.
  - res_data/res_carry/res_status hold their value until the next pulse.
- Latency: with an arbiter granting one cycle after req, a push at edge N gives:
  - req high after N+1;
  - gnt seen at N+3;
  - res_valid high in the cycle after N+3+HOLD_CYCLES.
- Minimum spacing: back-to-back ops are separated by at least one RELEASE cycle plus one IDLE cycle.

Decomposition:
- Package alu_req_pkg holds:
  - state encoding (IDLE/REQ/EXEC/RELEASE);
  - status codes (ST_OK, ST_TIMEOUT, ST_GRANT_LOST);
  - widths (OPA_W=2, OPB_W=2, SEL_W=4, RES_W=7);
  - the packed op record {sel, b, a}, 8 bits.
- One sub-module, alu_req_fifo:
  - parameterised depth and width;
  - push/pop/full/empty;
  - async active-high reset;
  - instantiated once.

Test Plan:
- Single add: push A=2,B=1,sel=0000, arbiter model grants 1 cycle after req, ALU model live -> req high 1 cycle after push; res_valid pulse with res_data=3, res_carry=0, res_status=00; req low, then busy=0 after gnt falls.
- Compare: push A=3,B=1,sel=1110 then A=2,B=2,sel=1111 back-to-back -> two pulses, res_data=1 then 1, each with status 00; req drops between them and stays low for at least 2 cycles.
- Timeout: gnt tied 0, push A=1,B=1,sel=0000 -> req high for exactly 15 cycles; then res_valid with status 01, res_data=0; req=0, FSM returns to IDLE.
- FIFO full: gnt tied 0, push 6 ops on consecutive cycles -> the first is popped and 4 more are accepted; op_ready=0 when the 6th is offered. After gnt is enabled, all 5 results come out in push order.
- Grant lost: HOLD_CYCLES=2, drop gnt in the first EXEC cycle -> res_valid with status 10, res_data=0; req deasserted the next cycle.
- Async reset in EXEC: assert reset between edges -> req, alu_a/alu_b/alu_sel, busy go 0 and op_ready goes 1 without a clock edge; no res_valid pulse; a new push after release behaves as in the single-add scenario.
